// File: rtl/store_commit_queue.sv
// In-order store commit queue between retire and the data-memory port.
// Loads own the port when present; stores drain otherwise, and a retired halt flushes the queue before reporting completion.
module store_commit_queue #(
  parameter int SQ_DEPTH = 4,
  parameter int XLEN     = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [1:0]                  store2Dmem_command,
  input  logic [1:0]                  store2Dmem_size,
  input  logic [XLEN-1:0]             store2Dmem_addr,
  input  logic [XLEN-1:0]             store2Dmem_data,
  input  logic                        halt_retired,
  input  logic                        load_req,
  input  logic [XLEN-1:0]             load_addr,
  input  logic [3:0]                  mem2proc_response,
  output logic [1:0]                  proc2Dmem_command,
  output logic [1:0]                  proc2Dmem_size,
  output logic [XLEN-1:0]             proc2Dmem_addr,
  output logic [XLEN-1:0]             proc2Dmem_data,
  output logic                        sq_full,
  output logic                        sq_empty,
  output logic [$clog2(SQ_DEPTH):0]   sq_count,
  output logic                        load_conflict,
  output logic                        overflow,
  output logic                        drained,
  output logic [1:0]                  dbg_state
);

  localparam int AW = $clog2(SQ_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_STORE = 2'h2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [SQ_DEPTH-1:0] valid_q, valid_d;
  logic [1:0]          size_q [SQ_DEPTH];
  logic [XLEN-1:0]     addr_q [SQ_DEPTH];
  logic [XLEN-1:0]     data_q [SQ_DEPTH];

  logic store_in, full, issue, pop, enq;

  // Handshake: a store entry leaves the queue only when it is presented
  // (issue) and memory answers with a nonzero tag in the same cycle; a zero
  // tag leaves the head in place to be re-presented unchanged.
  assign full     = (count_q == CW'(SQ_DEPTH));
  assign store_in = (store2Dmem_command == BUS_STORE) && (state_q != ST_DONE);
  assign issue    = (count_q != '0) && !load_req && (state_q != ST_DONE);
  assign pop      = issue && (mem2proc_response != 4'h0);
  assign enq      = store_in && (!full || pop);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    if (pop) begin
      head_d          = head_q + 1'b1;
      valid_d[head_q] = 1'b0;
    end
    // When full, head == tail, so the new entry's valid must win over the pop.
    if (enq) begin
      tail_d          = tail_q + 1'b1;
      valid_d[tail_q] = 1'b1;
    end
    if (enq && !pop)      count_d = count_q + 1'b1;
    else if (pop && !enq) count_d = count_q - 1'b1;
    if (store_in && !enq) overflow_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (halt_retired) state_d = ST_DRAIN;
      ST_DRAIN: if (!enq && ((count_q == '0) || ((count_q == CW'(1)) && pop)))
                  state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RUN;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset; valid_q decides what is meaningful.
  always_ff @(posedge clock) begin
    if (enq) begin
      size_q[tail_q] <= store2Dmem_size;
      addr_q[tail_q] <= store2Dmem_addr;
      data_q[tail_q] <= store2Dmem_data;
    end
  end

  always_comb begin
    load_conflict = 1'b0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i][XLEN-1:2] == load_addr[XLEN-1:2]))
        load_conflict = 1'b1;
    end
    if (enq && (store2Dmem_addr[XLEN-1:2] == load_addr[XLEN-1:2]))
      load_conflict = 1'b1;
  end

  assign proc2Dmem_command = issue ? BUS_STORE : BUS_NONE;
  assign proc2Dmem_size    = size_q[head_q];
  assign proc2Dmem_addr    = addr_q[head_q];
  assign proc2Dmem_data    = data_q[head_q];
  assign sq_full           = full;
  assign sq_empty          = (count_q == '0);
  assign sq_count          = count_q;
  assign overflow          = overflow_q;
  assign drained           = (state_q == ST_DONE);
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_store_commit_queue.sv
// Bench for store_commit_queue: queue-based reference model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_store_commit_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int W     = 2 + 2 * XLEN;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      store2Dmem_command, store2Dmem_size;
  logic [XLEN-1:0] store2Dmem_addr, store2Dmem_data;
  logic            halt_retired, load_req;
  logic [XLEN-1:0] load_addr;
  logic [3:0]      mem2proc_response;
  logic [1:0]      proc2Dmem_command, proc2Dmem_size;
  logic [XLEN-1:0] proc2Dmem_addr, proc2Dmem_data;
  logic            sq_full, sq_empty, load_conflict, overflow, drained;
  logic [2:0]      sq_count;
  logic [1:0]      dbg_state;

  // clock / reset
  always #5 clock = ~clock;

  store_commit_queue #(.SQ_DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .store2Dmem_command(store2Dmem_command), .store2Dmem_size(store2Dmem_size),
    .store2Dmem_addr(store2Dmem_addr), .store2Dmem_data(store2Dmem_data),
    .halt_retired(halt_retired), .load_req(load_req), .load_addr(load_addr),
    .mem2proc_response(mem2proc_response),
    .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_size(proc2Dmem_size),
    .proc2Dmem_addr(proc2Dmem_addr), .proc2Dmem_data(proc2Dmem_data),
    .sq_full(sq_full), .sq_empty(sq_empty), .sq_count(sq_count),
    .load_conflict(load_conflict), .overflow(overflow), .drained(drained),
    .dbg_state(dbg_state)
  );

  // scoreboard: pending stores as {size, addr, data}, oldest first
  logic [W-1:0] exp_q[$];
  bit m_drain, m_done, m_ovf;
  bit check_en = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_issue();
    return exp_q.size() > 0 && !load_req && !m_done;
  endfunction

  function automatic bit m_pop();
    return m_issue() && mem2proc_response != 4'h0;
  endfunction

  function automatic bit m_enq();
    return store2Dmem_command == 2'h2 && !m_done && (exp_q.size() < DEPTH || m_pop());
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_drain = 1'b0;
      m_done  = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      bit p, e, was_drain;
      p = m_pop();
      e = m_enq();
      was_drain = m_drain && !m_done;
      if (store2Dmem_command == 2'h2 && !m_done && !e) m_ovf = 1'b1;
      if (p) void'(exp_q.pop_front());
      if (e) exp_q.push_back({store2Dmem_size, store2Dmem_addr, store2Dmem_data});
      if (halt_retired && !m_drain) m_drain = 1'b1;
      if (was_drain && exp_q.size() == 0) m_done = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      bit conf;
      logic [W-1:0] h;
      logic [XLEN-1:0] a;
      conf = 1'b0;
      foreach (exp_q[i]) begin
        a = exp_q[i][63:32];
        if (a[31:2] == load_addr[31:2]) conf = 1'b1;
      end
      if (m_enq() && store2Dmem_addr[31:2] == load_addr[31:2]) conf = 1'b1;
      cmp("cmd", proc2Dmem_command, m_issue() ? 32'd2 : 32'd0);
      cmp("count", sq_count, exp_q.size());
      cmp("full", sq_full, exp_q.size() == DEPTH);
      cmp("empty", sq_empty, exp_q.size() == 0);
      cmp("conflict", load_conflict, conf);
      cmp("overflow", overflow, m_ovf);
      cmp("drained", drained, m_done);
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        cmp("head_size", proc2Dmem_size, h[65:64]);
        cmp("head_addr", proc2Dmem_addr, h[63:32]);
        cmp("head_data", proc2Dmem_data, h[31:0]);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    store2Dmem_command = 2'h0;
    store2Dmem_size    = 2'h0;
    store2Dmem_addr    = '0;
    store2Dmem_data    = '0;
    halt_retired       = 1'b0;
    load_req           = 1'b0;
    load_addr          = '0;
    mem2proc_response  = 4'h0;
  endtask

  task automatic drive_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    store2Dmem_command = 2'h2;
    store2Dmem_addr    = addr;
    store2Dmem_data    = data;
    store2Dmem_size    = size;
  endtask

  task automatic no_store();
    store2Dmem_command = 2'h0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check_en = 1'b1;
    #1;
    cmp("rst_cmd", proc2Dmem_command, 0);
    cmp("rst_empty", sq_empty, 1);
    cmp("rst_full", sq_full, 0);
    cmp("rst_drained", drained, 0);
    cmp("rst_conflict", load_conflict, 0);
    cmp("rst_ovf", overflow, 0);

    // single store, one-cycle latency, popped on first issue
    tick();
    drive_store(32'h100, 32'hDEADBEEF, 2'h2);
    mem2proc_response = 4'h1;
    #1 cmp("t1_not_yet", proc2Dmem_command, 0);
    tick();
    no_store();
    #1;
    cmp("t1_cmd", proc2Dmem_command, 2);
    cmp("t1_addr", proc2Dmem_addr, 32'h100);
    cmp("t1_data", proc2Dmem_data, 32'hDEADBEEF);
    tick();
    #1 cmp("t1_empty", sq_empty, 1);

    // fill, overflow, ordered drain
    mem2proc_response = 4'h0;
    for (int i = 0; i < 4; i++) begin
      drive_store(32'(i * 4), 32'hA0 + 32'(i), 2'h2);
      tick();
    end
    no_store();
    #1;
    cmp("t2_full", sq_full, 1);
    cmp("t2_count", sq_count, 4);
    drive_store(32'h40, 32'hBAD, 2'h2);
    tick();
    no_store();
    #1;
    cmp("t2_ovf", overflow, 1);
    cmp("t2_count5", sq_count, 4);
    cmp("t2_head", proc2Dmem_addr, 32'h0);
    mem2proc_response = 4'h1;
    for (int i = 0; i < 4; i++) begin
      #1 cmp("t2_order", proc2Dmem_addr, 32'(i * 4));
      tick();
    end
    #1 cmp("t2_empty", sq_empty, 1);

    // full with simultaneous enq + pop
    mem2proc_response = 4'h0;
    for (int i = 0; i < 4; i++) begin
      drive_store(32'h10 + 32'(i * 4), 32'hB0 + 32'(i), 2'h2);
      tick();
    end
    drive_store(32'h20, 32'hC0, 2'h2);
    mem2proc_response = 4'h1;
    #1 cmp("t3_count_pre", sq_count, 4);
    tick();
    no_store();
    mem2proc_response = 4'h0;
    #1;
    cmp("t3_count", sq_count, 4);
    cmp("t3_head", proc2Dmem_addr, 32'h14);
    mem2proc_response = 4'h1;
    for (int i = 0; i < 4; i++) begin
      #1 cmp("t3_order", proc2Dmem_addr, 32'h14 + 32'(i * 4));
      tick();
    end
    #1 cmp("t3_empty", sq_empty, 1);

    // load priority
    mem2proc_response = 4'h0;
    drive_store(32'h30, 32'h1, 2'h2);
    tick();
    drive_store(32'h34, 32'h2, 2'h2);
    tick();
    no_store();
    load_req = 1'b1;
    mem2proc_response = 4'h5;
    for (int i = 0; i < 3; i++) begin
      #1;
      cmp("t4_cmd_none", proc2Dmem_command, 0);
      cmp("t4_count", sq_count, 2);
      tick();
    end
    load_req = 1'b0;
    mem2proc_response = 4'h1;
    #1 cmp("t4_first", proc2Dmem_addr, 32'h30);
    tick();
    #1 cmp("t4_second", proc2Dmem_addr, 32'h34);
    tick();
    #1 cmp("t4_empty", sq_empty, 1);

    // word-granular conflict detection
    mem2proc_response = 4'h0;
    drive_store(32'h104, 32'h55, 2'h0);
    tick();
    no_store();
    load_addr = 32'h107;
    #1 cmp("t5_alias", load_conflict, 1);
    load_addr = 32'h108;
    #1 cmp("t5_noalias", load_conflict, 0);
    drive_store(32'h108, 32'h66, 2'h2);
    load_addr = 32'h10A;
    #1 cmp("t5_incoming", load_conflict, 1);
    tick();
    no_store();
    load_addr = 32'h0;
    mem2proc_response = 4'h1;
    repeat (2) tick();
    #1 cmp("t5_empty", sq_empty, 1);

    // halt drain
    mem2proc_response = 4'h0;
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h200 + 32'(i * 4), 32'hE0 + 32'(i), 2'h2);
      tick();
    end
    no_store();
    halt_retired = 1'b1;
    mem2proc_response = 4'h1;
    tick();
    halt_retired = 1'b0;
    #1;
    cmp("t6_not_done", drained, 0);
    cmp("t6_count2", sq_count, 2);
    repeat (2) tick();
    #1;
    cmp("t6_drained", drained, 1);
    cmp("t6_empty", sq_empty, 1);
    drive_store(32'h300, 32'h77, 2'h2);
    #1 cmp("t6_no_issue", proc2Dmem_command, 0);
    tick();
    no_store();
    #1;
    cmp("t6_ignored", sq_empty, 1);
    cmp("t6_held", drained, 1);

    // reset during drain
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    cmp("t7_rst_drained", drained, 0);
    cmp("t7_rst_ovf", overflow, 0);
    mem2proc_response = 4'h0;
    drive_store(32'h400, 32'h1, 2'h2);
    tick();
    drive_store(32'h404, 32'h2, 2'h2);
    tick();
    no_store();
    halt_retired = 1'b1;
    tick();
    halt_retired = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    cmp("t7_cmd", proc2Dmem_command, 0);
    cmp("t7_empty", sq_empty, 1);
    cmp("t7_drained", drained, 0);
    cmp("t7_count", sq_count, 0);
    mem2proc_response = 4'h1;
    repeat (3) tick();
    #1;
    cmp("t7_quiet", proc2Dmem_command, 0);
    cmp("t7_still_empty", sq_empty, 1);

    repeat (2) tick();
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_commit_queue.md
Name: store_commit_queue

Overview:
- Sits directly downstream of the retire stage.
- Captures each retired store (BUS_STORE command, size, address, data) into an in-order FIFO. Drains the FIFO to the data-memory port whenever the load path is not using that port.
- Flags pending stores that alias a load's word address, so the LSU holds the load.
- On a retired halt, drains every pending store before reporting completion to the pipeline.

Parameters:
- SQ_DEPTH, 4: number of store entries; power of two, at least 2.
- XLEN, 32: address and data width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- store2Dmem_command  in  2  retire store request; BUS_STORE=2'h2 enqueues, any other value is ignored
- store2Dmem_size  in  2  MEM_SIZE of the store (BYTE/HALF/WORD)
- store2Dmem_addr  in  XLEN  store address
- store2Dmem_data  in  XLEN  store data
- halt_retired  in  1  one-cycle pulse; a halt instruction retired this cycle
- load_req  in  1  LSU owns the Dmem port this cycle (highest priority)
- load_addr  in  XLEN  address of the LSU load being checked
- mem2proc_response  in  4  memory tag; nonzero means the current command was accepted
- proc2Dmem_command  out  2  BUS_STORE or BUS_NONE
- proc2Dmem_size  out  2  size of the head entry
- proc2Dmem_addr  out  XLEN  address of the head entry
- proc2Dmem_data  out  XLEN  data of the head entry
- sq_full  out  1  count == SQ_DEPTH; retire must not present a store
- sq_empty  out  1  count == 0
- sq_count  out  $clog2(SQ_DEPTH)+1  number of occupied entries
- load_conflict  out  1  a pending or incoming store aliases load_addr at word granularity
- overflow  out  1  sticky error: a store arrived while full with no pop
- drained  out  1  halt seen and FIFO empty; held until reset

Behaviour:
- Reset, applied at the clock edge: head=0, tail=0, count=0, state=RUN, overflow=0. All entries are invalid.
  - Reset outputs: proc2Dmem_command=BUS_NONE, sq_empty=1, sq_full=0, drained=0, load_conflict=0.
  - Reset mid-drain discards all pending stores; nothing is written afterwards.
- Enqueue (enq): store2Dmem_command==BUS_STORE and (count<SQ_DEPTH or pop this cycle).
  - Writes the entry at tail; tail advances modulo SQ_DEPTH.
  - If the FIFO is full and there is no pop, the store is dropped and overflow sets.
- Issue, combinational from the registered head entry: when !sq_empty and !load_req and state!=DONE, proc2Dmem_command=BUS_STORE with the head size, addr and data. Otherwise it is BUS_NONE.
  - proc2Dmem_addr/data/size still follow the head entry when the command is BUS_NONE; they are don't-care when empty.
- Pop: issuing and mem2proc_response!=0 in the same cycle. Head advances at the clock edge.
  - If the response is 0, the same head is re-presented next cycle (same values, no reordering).
  - A nonzero response while load_req=1 belongs to the load and does not pop.
- Same-cycle enq and pop: both happen and count is unchanged. This is legal when full.
- A newly enqueued entry is visible at issue no earlier than the next cycle (1-cycle minimum latency from retire to Dmem).
- Pointer wrap: head and tail wrap at SQ_DEPTH-1 → 0. Occupancy is tracked by count, not by pointer compare.
- load_conflict is combinational. It is 1 if either:
  - any valid entry has addr[XLEN-1:2]==load_addr[XLEN-1:2], or
  - the incoming enq store matches.
  - Size is ignored (conservative word aliasing).
  - The head entry being popped this cycle still counts.
- FSM:
  - RUN: on halt_retired → DRAIN. If halt_retired arrives in the same cycle as the last store's enq, that store is included.
  - DRAIN: enqueue is still accepted (stores retiring with the halt). When count==0, or count==1 with pop and no enq → DONE at the next edge.
  - DONE: drained=1, issue is suppressed, enq is ignored. The state holds until reset.
- Width: sq_count is the unsigned occupancy; no other arithmetic beyond pointer increments.

Test Plan:
- Single store: addr 0x100, data 0xDEADBEEF, WORD; response=1 on the first issue cycle → BUS_STORE seen exactly 1 cycle after enq, popped, sq_empty=1 two cycles after enq.
- Fill and back-pressure: 4 stores (addr 0x0,0x4,0x8,0xC) with response=0 → sq_full=1, sq_count=4.
  - A 5th store with no pop sets overflow=1 and is dropped.
  - Releasing response=1 drains in order 0x0..0xC over 4 cycles.
- Full with simultaneous enq+pop: count=4, store 0x20 enq while head accepted → count stays 4, tail wraps to 0, 0x20 issues last.
- Load priority: 2 pending stores, load_req=1 for 3 cycles with response=5 → command=BUS_NONE, no pop. After load_req drops, stores issue in order.
- Conflict: pending store at 0x104 (BYTE); load_addr 0x107 → load_conflict=1; load_addr 0x108 → 0. An incoming enq at 0x108 with load_addr 0x10A → 1.
- Halt drain plus reset: 3 pending stores, halt_retired pulse, response=1 → drained=1 after the 3rd pop, later stores ignored. Separate run: reset asserted during DRAIN with 2 pending → next cycle BUS_NONE, sq_empty=1, drained=0.
